result_read_fsm: RTL and testbench

RESULT_READ_FSM -- requirements
Module: result_read_fsm

---
 rtl/result_read_if.sv | 20 ++
 rtl/result_read_fsm.sv | 151 +++++++++++++++
 tb/tb_result_read_fsm.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_read_if.sv
// Result memory read port plus host-side record stream.
// The reader drives the master side; memory and host sit on the slave side.
interface result_read_if;
    logic [15:0] addr_out;
    logic        read_enable;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output addr_out, read_enable, out_data, out_valid,
        input  rd_data, out_ready
    );

    modport slave (
        input  addr_out, read_enable, out_data, out_valid,
        output rd_data, out_ready
    );
endinterface

// File: rtl/result_read_fsm.sv
// Drains filled result slots word by word toward the host, then frees them.
// Optional RESULT_READ_DROP_CNT_EN adds an 8-bit saturating drop_count output.
module result_read_fsm #(
    parameter int          NUM_SLOTS    = 5,
    parameter logic [15:0] SLOT_STRIDE  = 16'h060E,
    parameter int          RECORD_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slot_done,
    result_read_if.master      bus,
    output logic               slot_release,
    output logic               empty,
    output logic               full,
    output logic               overflow
`ifdef RESULT_READ_DROP_CNT_EN
    ,
    output logic [7:0]         drop_count
`endif
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int WW = (RECORD_WORDS > 1) ? $clog2(RECORD_WORDS) : 1;
    localparam int CW = $clog2(NUM_SLOTS + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        HOLD,
        RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [WW-1:0] word_q, word_d;
    logic [15:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
`ifdef RESULT_READ_DROP_CNT_EN
    logic [7:0]    drop_q, drop_d;
`endif

    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        slot_d       = slot_q;
        word_d       = word_q;
        addr_d       = addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        ovf_d        = ovf_q;
`ifdef RESULT_READ_DROP_CNT_EN
        drop_d       = drop_q;
`endif
        slot_release = (state_q == RELEASE);
        empty        = (occ_q == '0);
        full         = (occ_q == CW'(NUM_SLOTS));

        unique case (state_q)
            IDLE: begin
                if (occ_q != '0) begin
                    word_d  = '0;
                    state_d = READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                data_d  = bus.rd_data;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (word_q == WW'(RECORD_WORDS - 1)) begin
                        state_d = RELEASE;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            RELEASE: begin
                slot_d  = (slot_q == SW'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Address is latched on entry to READ so it holds in every other state.
        if (state_d == READ) begin
            addr_d = 16'(32'(slot_q) * 32'(SLOT_STRIDE) + 32'(word_d) * 32'd4);
        end

        unique case ({slot_done, slot_release})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
`ifdef RESULT_READ_DROP_CNT_EN
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
`endif
                end else begin
                    occ_d = occ_q + 1'b1;
                end
            end
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            slot_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef RESULT_READ_DROP_CNT_EN
            drop_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            slot_q  <= slot_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef RESULT_READ_DROP_CNT_EN
            drop_q  <= drop_d;
`endif
        end
    end

    assign bus.addr_out    = addr_q;
    assign bus.read_enable = (state_q == READ);
    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign overflow        = ovf_q;
`ifdef RESULT_READ_DROP_CNT_EN
    assign drop_count      = drop_q;
`endif

endmodule

// File: tb/tb_result_read_fsm.sv
// Scoreboarded bench for result_read_fsm: memory model, host sink,
// occupancy-flag table and hand-written corner sequences.
module tb_result_read_fsm;

    logic clk = 1'b0;
    logic rst;
    logic slot_done;
    logic slot_release, empty, full, overflow;
`ifdef RESULT_READ_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    result_read_if bus();

    result_read_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .slot_done    (slot_done),
        .bus          (bus),
        .slot_release (slot_release),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
`ifdef RESULT_READ_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   n_done;
        bit   drop;
        logic e_empty;
        logic e_full;
        logic e_ovf;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rel_cnt = 0;
    int          rel_exp = 0;
    int          sb_slot = 0;
    int          t_first_re = -1;
    int          t_rel = -1;
    logic [15:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [15:0] bases[5];
    vec_t        vecs[4];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model: data one cycle after the read strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.read_enable) bus.rd_data <= mem_word(bus.addr_out);
        else                 bus.rd_data <= 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.read_enable) begin
                if (t_first_re < 0) t_first_re = cyc;
                check("re_while_valid", {31'b0, bus.out_valid}, 32'd0);
                if (exp_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_read: addr %h, none expected",
                             bus.addr_out);
                end else begin
                    check("addr_out", {16'b0, bus.addr_out},
                          {16'b0, exp_addr.pop_front()});
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_data.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: data %h, none expected",
                             bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_data.pop_front());
                end
            end
            if (slot_release) begin
                rel_cnt++;
                t_rel = cyc;
            end
        end
    end

    task automatic push_slot();
        logic [15:0] a;
        for (int w = 0; w < 4; w++) begin
            a = bases[sb_slot] + 16'(4 * w);
            exp_addr.push_back(a);
            exp_data.push_back(mem_word(a));
        end
        rel_exp++;
        sb_slot = (sb_slot == 4) ? 0 : sb_slot + 1;
    endtask

    task automatic pulse_done(input bit drop);
        @(posedge clk);
        #1;
        slot_done = 1'b1;
        if (!drop) push_slot();
        @(posedge clk);
        #1;
        slot_done = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(exp_addr.size() == 0 && exp_data.size() == 0 &&
                     rel_cnt == rel_exp && empty === 1'b1) && n < max);
        check({name, "_timeout"}, {31'b0, n < max}, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_addr.delete();
        exp_data.delete();
        sb_slot = 0;
        rel_cnt = 0;
        rel_exp = 0;
        @(negedge clk);
        check("rst_addr",    {16'b0, bus.addr_out}, 32'd0);
        check("rst_re",      {31'b0, bus.read_enable}, 32'd0);
        check("rst_data",    bus.out_data, 32'd0);
        check("rst_valid",   {31'b0, bus.out_valid}, 32'd0);
        check("rst_release", {31'b0, slot_release}, 32'd0);
        check("rst_empty",   {31'b0, empty}, 32'd1);
        check("rst_full",    {31'b0, full}, 32'd0);
        check("rst_ovf",     {31'b0, overflow}, 32'd0);
`ifdef RESULT_READ_DROP_CNT_EN
        check("rst_drop",    {24'b0, drop_count}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        int          n;
        bases = '{16'h0000, 16'h060E, 16'h0C1C, 16'h122A, 16'h1838};
        vecs  = '{'{1, 1'b0, 1'b0, 1'b0, 1'b0},
                  '{3, 1'b0, 1'b0, 1'b0, 1'b0},
                  '{1, 1'b0, 1'b0, 1'b1, 1'b0},
                  '{1, 1'b1, 1'b0, 1'b1, 1'b1}};
        rst           = 1'b1;
        slot_done     = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        // Single slot, host always ready
        bus.out_ready = 1'b1;
        t_first_re = -1;
        pulse_done(1'b0);
        drain("one_slot", 100);
        check("one_slot_rel",    rel_cnt, 32'd1);
        check("one_slot_empty",  {31'b0, empty}, 32'd1);
        check("one_slot_cycles", t_rel - t_first_re, 32'd12);

        // Fill to full and beyond while the host stalls
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < vecs[i].n_done; k++) pulse_done(vecs[i].drop);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_empty", i), {31'b0, empty},
                  {31'b0, vecs[i].e_empty});
            check($sformatf("vec%0d_full", i), {31'b0, full},
                  {31'b0, vecs[i].e_full});
            check($sformatf("vec%0d_ovf", i), {31'b0, overflow},
                  {31'b0, vecs[i].e_ovf});
        end
`ifdef RESULT_READ_DROP_CNT_EN
        check("drop_count", {24'b0, drop_count}, 32'd1);
`endif

        // Stalled HOLD keeps word stable, no new read
        @(negedge clk);
        held = bus.out_data;
        check("hold_first_word", held, mem_word(16'h0000));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_data",  bus.out_data, held);
            check("hold_no_re", {31'b0, bus.read_enable}, 32'd0);
        end
        bus.out_ready = 1'b1;
        drain("five_slots", 400);
        check("five_slots_rel", rel_cnt, 32'd5);
        pulse_done(1'b0);
        drain("sixth_slot", 100);
        check("sixth_slot_rel", rel_cnt, 32'd6);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // slot_done coincident with slot_release at occupancy 1
        t_first_re = -1;
        pulse_done(1'b0);
        n = 0;
        while (t_first_re < 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("coinc_start", {31'b0, t_first_re >= 0}, 32'd1);
        repeat (11) @(posedge clk);
        pulse_done(1'b0);
        check("coinc_align", t_rel - t_first_re, 32'd12);
        check("coinc_occ",   {31'b0, empty}, 32'd0);
        drain("coinc", 100);
        check("coinc_rel", rel_cnt, 32'd8);

        // Reset mid-record
        pulse_done(1'b0);
        n = 0;
        while (exp_data.size() > 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reach", {31'b0, n < 50}, 32'd1);
        do_reset();
        repeat (5) @(negedge clk);
        check("abort_no_rel", rel_cnt, 32'd0);
        pulse_done(1'b0);
        drain("after_abort", 100);
        check("after_abort_rel", rel_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
